// File: rtl/zlib_stream_packer.sv
// zlib stream packer: frames pre-encoded fixed-Huffman symbols into a complete zlib
// stream (header, final block header, EOB, byte alignment, Adler-32 trailer).
module zlib_stream_packer #(
  parameter int         DATA_WD = 32,
  parameter int         SYM_WD  = 24,
  parameter int         LEN_WD  = 5,
  parameter logic [7:0] CMF     = 8'h78,
  parameter logic [7:0] FLG     = 8'h01,
  parameter int         NUM_WD  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               sym_val_i,
  output logic               sym_rdy_o,
  input  logic [SYM_WD-1:0]  sym_dat_i,
  input  logic [LEN_WD-1:0]  sym_len_i,
  input  logic               sym_lst_i,
  input  logic               raw_val_i,
  output logic               raw_rdy_o,
  input  logic [7:0]         raw_dat_i,
  input  logic               raw_lst_i,
  output logic               val_o,
  input  logic               rdy_i,
  output logic [DATA_WD-1:0] dat_o,
  output logic [NUM_WD-1:0]  num_o,
  output logic               lst_o,
  output logic               done_o,
  output logic               busy_o
);

  localparam int ACC_WD  = 2 * DATA_WD;
  localparam int FILL_WD = $clog2(ACC_WD) + 1;
  localparam logic [FILL_WD-1:0] WORD_BITS  = FILL_WD'(DATA_WD);
  localparam logic [NUM_WD-1:0]  WORD_BYTES = NUM_WD'(DATA_WD / 8);
  localparam logic [16:0]        ADLER_MOD  = 17'd65521;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_HDR   = 4'd1;
  localparam logic [3:0] S_BHDR  = 4'd2;
  localparam logic [3:0] S_DATA  = 4'd3;
  localparam logic [3:0] S_EOB   = 4'd4;
  localparam logic [3:0] S_ALIGN = 4'd5;
  localparam logic [3:0] S_AWAIT = 4'd6;
  localparam logic [3:0] S_ADLER = 4'd7;
  localparam logic [3:0] S_FLUSH = 4'd8;

  if ((int'(CMF) * 256 + int'(FLG)) % 31 != 0) begin : g_bad_fcheck
    $error("zlib_stream_packer: CMF/FLG pair fails the FCHECK rule");
  end
  if (SYM_WD > DATA_WD) begin : g_bad_sym_wd
    $error("zlib_stream_packer: SYM_WD must not exceed DATA_WD");
  end

  logic [3:0]         state_q, state_d;
  logic [ACC_WD-1:0]  acc_q, acc_d;
  logic [FILL_WD-1:0] fill_q, fill_d;
  logic [2:0]         bcnt_q, bcnt_d;
  logic [15:0]        s1_q, s1_d, s2_q, s2_d;
  logic               raw_done_q, raw_done_d;
  logic               done_q, done_d;

  logic               in_flush, can_push, pop, push;
  logic [FILL_WD-1:0] push_len, pop_len, fill_base;
  logic [DATA_WD-1:0] push_val, sym_mask;
  logic [ACC_WD-1:0]  acc_base;
  logic [2:0]         bcnt_eob;
  logic [16:0]        s1_sum, s2_sum;
  logic [15:0]        s1_new, s2_new;

  assign in_flush  = (state_q == S_FLUSH);
  assign can_push  = (fill_q < WORD_BITS);
  assign val_o     = (fill_q >= WORD_BITS) | (in_flush & (fill_q != '0));
  assign lst_o     = in_flush & (fill_q != '0) & (fill_q <= WORD_BITS);
  assign pop       = val_o & rdy_i;
  assign dat_o     = acc_q[DATA_WD-1:0];
  assign num_o     = !val_o ? '0 :
                     (in_flush & (fill_q < WORD_BITS)) ? NUM_WD'((fill_q + FILL_WD'(7)) >> 3) :
                     WORD_BYTES;
  assign busy_o    = (state_q != S_IDLE);
  assign sym_rdy_o = (state_q == S_DATA) & can_push;
  assign raw_rdy_o = busy_o & ~raw_done_q;
  assign done_o    = done_q;
  assign sym_mask  = (DATA_WD'(1) << sym_len_i) - DATA_WD'(1);
  assign bcnt_eob  = bcnt_q + 3'd7;

  // Stream sequencer: each framing state contributes one push once there is room.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    push_len = '0;
    push_val = '0;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_HDR;
      S_HDR: if (can_push) begin
        push = 1'b1; push_len = FILL_WD'(16); push_val = DATA_WD'({FLG, CMF});
        state_d = S_BHDR;
      end
      S_BHDR: if (can_push) begin
        push = 1'b1; push_len = FILL_WD'(3); push_val = DATA_WD'(3'b011);
        state_d = S_DATA;
      end
      S_DATA: if (sym_val_i & can_push) begin
        push = 1'b1; push_len = FILL_WD'(sym_len_i);
        push_val = DATA_WD'(sym_dat_i) & sym_mask;
        if (sym_lst_i) state_d = S_EOB;
      end
      S_EOB: if (can_push) begin
        push = 1'b1; push_len = FILL_WD'(7);
        state_d = (bcnt_eob != 3'd0) ? S_ALIGN : S_AWAIT;
      end
      S_ALIGN: if (can_push) begin
        push = 1'b1; push_len = FILL_WD'(4'd8 - {1'b0, bcnt_q});
        state_d = S_AWAIT;
      end
      S_AWAIT: if (raw_done_q) state_d = S_ADLER;
      S_ADLER: if (can_push) begin
        push = 1'b1; push_len = FILL_WD'(32);
        push_val = DATA_WD'({s1_q[7:0], s1_q[15:8], s2_q[7:0], s2_q[15:8]});
        state_d = S_FLUSH;
      end
      S_FLUSH: if (pop & lst_o) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator: retire the output word first, then append the new field above what remains.
  always_comb begin
    pop_len   = (in_flush & (fill_q < WORD_BITS)) ? fill_q : WORD_BITS;
    acc_base  = pop ? (acc_q >> DATA_WD) : acc_q;
    fill_base = pop ? (fill_q - pop_len) : fill_q;
    acc_d     = acc_base;
    fill_d    = fill_base;
    bcnt_d    = bcnt_q;
    if (push) begin
      acc_d  = acc_base | ({{DATA_WD{1'b0}}, push_val} << fill_base);
      fill_d = fill_base + push_len;
      bcnt_d = bcnt_q + push_len[2:0];
    end
    if ((state_q == S_IDLE) & start_i) bcnt_d = '0;
    done_d = pop & lst_o;
  end

  always_comb begin
    s1_sum     = {1'b0, s1_q} + {9'b0, raw_dat_i};
    s1_new     = 16'((s1_sum >= ADLER_MOD) ? s1_sum - ADLER_MOD : s1_sum);
    s2_sum     = {1'b0, s2_q} + {1'b0, s1_new};
    s2_new     = 16'((s2_sum >= ADLER_MOD) ? s2_sum - ADLER_MOD : s2_sum);
    s1_d       = s1_q;
    s2_d       = s2_q;
    raw_done_d = raw_done_q;
    if ((state_q == S_IDLE) & start_i) begin
      s1_d = 16'd1; s2_d = 16'd0; raw_done_d = 1'b0;
    end else if (raw_val_i & raw_rdy_o) begin
      s1_d = s1_new; s2_d = s2_new; raw_done_d = raw_lst_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      fill_q     <= '0;
      bcnt_q     <= '0;
      s1_q       <= 16'd1;
      s2_q       <= 16'd0;
      raw_done_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      bcnt_q     <= bcnt_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      raw_done_q <= raw_done_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: doc/zlib_stream_packer.md
Name: zlib_stream_packer

Overview:
- Parametrised successor to the fixed-Huffman zlib framer.
- Wraps pre-encoded deflate symbols into a complete zlib stream: CMF/FLG header, single final fixed-Huffman block, EOB, byte alignment, and a computed Adler-32 trailer.
- Adds three things the previous generation lacked: an internal Adler-32 engine fed from the raw byte stream, valid/ready backpressure on the output, and a byte count on the final word.
- Sits between the Huffman symbol encoder and the PNG IDAT chunk writer.

Parameters:
- DATA_WD, 32: output word width; 32 or 64.
- SYM_WD, 24: max symbol field width in bits; SYM_WD <= DATA_WD.
- LEN_WD, 5: width of the symbol length field; must hold SYM_WD.
- CMF, 8'h78: zlib CMF byte.
- FLG, 8'h01: zlib FLG byte. (CMF*256+FLG) % 31 == 0 is required and checked by an elaboration assertion.
- NUM_WD, 4: width of num_o; must hold DATA_WD/8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start_i  in  1  begin a stream; ignored unless IDLE
- sym_val_i  in  1  symbol valid
- sym_rdy_o  out  1  symbol accepted when val&rdy
- sym_dat_i  in  SYM_WD  code bits, LSB = first stream bit
- sym_len_i  in  LEN_WD  bit count 0..SYM_WD; 0 = no-op
- sym_lst_i  in  1  last symbol of the block
- raw_val_i  in  1  uncompressed byte valid
- raw_rdy_o  out  1  raw byte accepted when val&rdy
- raw_dat_i  in  8  uncompressed byte for Adler-32
- raw_lst_i  in  1  last raw byte; at least 1 byte per stream
- val_o  out  1  output word valid
- rdy_i  in  1  downstream ready
- dat_o  out  DATA_WD  stream word; byte 0 = dat_o[7:0], LSB-first bits
- num_o  out  NUM_WD  valid bytes in dat_o, 1..DATA_WD/8
- lst_o  out  1  final word of stream
- done_o  out  1  1-cycle pulse when the final word handshakes
- busy_o  out  1  high from start accept until done_o

Behaviour:
Reset: all outputs 0, state IDLE, bit accumulator empty (fill=0), s1=1, s2=0.

Bit packer:
- Accumulator is 2*DATA_WD bits with a fill counter.
- A push appends a field at bit position fill.
- A push is allowed only when fill < DATA_WD.
- val_o = (fill >= DATA_WD) | (state==FLUSH & fill>0).
- On val_o & rdy_i: shift out DATA_WD bits and reduce fill; pop and push in the same cycle are legal.
- num_o = DATA_WD/8 except in FLUSH, where it is ceil(fill/8).
- lst_o = 1 on the word that leaves fill=0 in FLUSH.
- No bubbles beyond the 1-cycle register; the output is registered, with latency 1 cycle from push to val_o.

FSM (one push per state, stalling while fill >= DATA_WD):
- IDLE: start_i -> HDR; clear s1=1, s2=0.
- HDR: push 16 bits {FLG,CMF} -> BHDR.
- BHDR: push 3'b011 (BFINAL=1, BTYPE=01) -> DATA.
- DATA:
  - sym_rdy_o = (fill < DATA_WD); accepted symbols are pushed.
  - Accepted sym_lst_i -> EOB.
  - sym_val_i is ignored outside DATA (sym_rdy_o=0).
- EOB: push 7'b0 -> ALIGN if (bit count mod 8) != 0, else ADLER_WAIT.
- ALIGN: push (8 - bitcount mod 8) zeros -> ADLER_WAIT.
- ADLER_WAIT: wait until the raw last byte has been absorbed -> ADLER.
- ADLER: push 32 bits as bytes s2[15:8], s2[7:0], s1[15:8], s1[7:0] in stream order -> FLUSH.
- FLUSH: drain; the handshake of the lst_o word -> IDLE with done_o pulsed and busy_o dropped.

Adler-32:
- raw_rdy_o = busy_o & ~raw_done.
- Per accepted byte, one byte per cycle:
  - s1' = s1 + b, minus 65521 if >= 65521;
  - s2' = s2 + s1', minus 65521 if >= 65521.
- Raw and symbol streams are independent; either may finish first.

Boundaries:
- start_i while busy is ignored.
- A symbol exactly filling to DATA_WD is legal.
- A zero-length symbol with sym_lst_i still closes the block.
- rst mid-stream returns the block to the reset state immediately, with no partial output.
- rdy_i low holds dat_o/num_o/lst_o stable while val_o is high.

Test Plan:
1. DATA_WD=32, single raw byte 0x61 with symbol code for 'a' (bit-reversed 8'b10010001, len 8, lst) -> words 0x044B0178, 0x00620000, then 0x00000062 with num_o=1, lst_o=1, done_o pulse.
2. Same stimulus, DATA_WD=64 -> 0x00620000044B0178 (num 8), then 0x62 with num_o=1, lst_o=1.
3. 300 raw bytes of 0xFF with any symbol stream -> trailer bytes B9 0F 2A E4 (Adler 0xB90F2AE4; exercises s1 and s2 modulo wrap).
4. Test 1 with rdy_i toggled 1-of-3 cycles -> identical word sequence; dat_o stable while val_o & !rdy_i; sym_rdy_o low whenever fill >= 32.
5. start_i pulsed again mid-DATA; sym_lst_i before raw_lst_i and vice versa -> the second start is ignored, and both orders give the same output.
6. Assert rst during DATA with fill > 0 -> the next cycle shows val_o=0, busy_o=0, sym_rdy_o=0; a fresh test-1 stream then reproduces test-1 output exactly.
